// File: rtl/mem_copy_engine.sv
// Word-at-a-time block copy initiator for a single-port memory (READ then WRITE per word).
// Optional running checksum of copied data is enabled with MEMCOPY_CHECKSUM_EN.
module mem_copy_engine #(
    parameter int unsigned N     = 16,
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [N-1:0]     src,
    input  logic [N-1:0]     dst,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     mem_address,
    output logic [N-1:0]     mem_in,
    output logic             mem_write_en,
    input  logic [N-1:0]     mem_out
`ifdef MEMCOPY_CHECKSUM_EN
    ,
    output logic [N-1:0]     checksum
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e           state_q;
    logic [N-1:0]     src_q;
    logic [N-1:0]     dst_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] i_q;
    logic [N-1:0]     data_q;
    logic [N-1:0]     mem_address_q;
    logic             mem_write_en_q;
    logic             busy_q;
    logic             done_q;
`ifdef MEMCOPY_CHECKSUM_EN
    logic [N-1:0]     checksum_q;
`endif

    logic [LEN_W-1:0] i_d;
    logic [N-1:0]     rd_addr_d;
    logic [N-1:0]     wr_addr_d;

    // Address arithmetic wraps naturally at N bits.
    assign i_d       = i_q + LEN_W'(1);
    assign rd_addr_d = src_q + N'(i_d);
    assign wr_addr_d = dst_q + N'(i_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            src_q          <= '0;
            dst_q          <= '0;
            len_q          <= '0;
            i_q            <= '0;
            data_q         <= '0;
            mem_address_q  <= '0;
            mem_write_en_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
`ifdef MEMCOPY_CHECKSUM_EN
            checksum_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    mem_address_q  <= '0;
                    mem_write_en_q <= 1'b0;
                    data_q         <= '0;
                    done_q         <= 1'b0;
                    busy_q         <= 1'b0;
                    if (start) begin
                        src_q  <= src;
                        dst_q  <= dst;
                        len_q  <= len;
                        i_q    <= '0;
                        busy_q <= 1'b1;
`ifdef MEMCOPY_CHECKSUM_EN
                        checksum_q <= '0;
`endif
                        if (len != '0) begin
                            state_q       <= READ;
                            mem_address_q <= src;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    state_q        <= WRITE;
                    data_q         <= mem_out;
                    mem_address_q  <= wr_addr_d;
                    mem_write_en_q <= 1'b1;
`ifdef MEMCOPY_CHECKSUM_EN
                    checksum_q     <= checksum_q + mem_out;
`endif
                end
                WRITE: begin
                    i_q            <= i_d;
                    data_q         <= '0;
                    mem_write_en_q <= 1'b0;
                    if (i_d == len_q) begin
                        state_q       <= DONE;
                        done_q        <= 1'b1;
                        mem_address_q <= '0;
                    end else begin
                        state_q       <= READ;
                        mem_address_q <= rd_addr_d;
                    end
                end
                DONE: begin
                    state_q        <= IDLE;
                    busy_q         <= 1'b0;
                    done_q         <= 1'b0;
                    mem_address_q  <= '0;
                    mem_write_en_q <= 1'b0;
                    data_q         <= '0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign mem_address  = mem_address_q;
    assign mem_in       = data_q;
    assign mem_write_en = mem_write_en_q;
`ifdef MEMCOPY_CHECKSUM_EN
    assign checksum     = checksum_q;
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: memory model, write scoreboard and table of copy transfers.
// Define MEMCOPY_CHECKSUM_EN to also check the checksum output.
module tb_mem_copy_engine;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic [15:0] mem_address;
    logic [15:0] mem_in;
    logic        mem_write_en;
    logic [15:0] mem_out;
`ifdef MEMCOPY_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    mem_copy_engine #(.N(16), .LEN_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .src          (src),
        .dst          (dst),
        .len          (len),
        .busy         (busy),
        .done         (done),
        .mem_address  (mem_address),
        .mem_in       (mem_in),
        .mem_write_en (mem_write_en),
        .mem_out      (mem_out)
`ifdef MEMCOPY_CHECKSUM_EN
        ,
        .checksum     (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];

    // Memory with address 0 hard-wired to read as zero.
    assign mem_out = (mem_address == 16'h0000) ? 16'h0000 : mem[mem_address];
    always @(posedge clk) begin
        if (mem_write_en) mem[mem_address] = mem_in;
    end

    int vectors     = 0;
    int miscompares = 0;
    int wr_cnt      = 0;
    int done_cnt    = 0;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;
    wr_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: every write pulse must match the next expected (addr, data).
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (mem_write_en === 1'b1) begin
            wr_cnt++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_address, mem_in);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (mem_address !== e.addr || mem_in !== e.data) begin
                    miscompares++;
                    $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                             mem_address, mem_in, e.addr, e.data);
                end
            end
        end
    end

    function automatic logic [15:0] pat(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        mem[a]     = d;
        ref_mem[a] = d;
    endtask

    typedef struct {
        logic [15:0] src;
        logic [15:0] dst;
        int          len;
        int          glitch;
        bit          sod;
        int          exp_lat;
    } vec_t;

    task automatic run_vec(input vec_t v, input int idx);
        int          n;
        int          wr0;
        int          dn0;
        logic [15:0] a_s;
        logic [15:0] a_d;
        logic [15:0] d;
        logic [15:0] cs;
        cs = 16'h0000;
        // Reference: strictly ascending word copy on the shadow memory.
        for (int k = 0; k < v.len; k++) begin
            a_s = v.src + 16'(k);
            a_d = v.dst + 16'(k);
            d   = (a_s == 16'h0000) ? 16'h0000 : ref_mem[a_s];
            cs  = cs + d;
            ref_mem[a_d] = d;
            exp_q.push_back('{addr: a_d, data: d});
        end
        wr0 = wr_cnt;
        dn0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        src   = v.src;
        dst   = v.dst;
        len   = 16'(v.len);
        @(posedge clk); #1;
        start = 1'b0;
        src   = 16'($urandom);
        dst   = 16'($urandom);
        len   = 16'($urandom);
        n = 0;
        while (done !== 1'b1 && n < 2 * v.len + 10) begin
            if (n == v.glitch) begin
                start = 1'b1;
                src   = v.src + 16'h0055;
                dst   = v.dst + 16'h0077;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk($sformatf("v%0d_done_latency", idx), 32'(n), 32'(v.exp_lat));
        chk($sformatf("v%0d_busy_in_done", idx), 32'(busy), 32'd1);
        if (v.sod) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk($sformatf("v%0d_done_width", idx), 32'(done), 32'd0);
        chk($sformatf("v%0d_busy_after", idx), 32'(busy), 32'd0);
`ifdef MEMCOPY_CHECKSUM_EN
        chk($sformatf("v%0d_checksum", idx), 32'(checksum), 32'(cs));
        if (idx == 0) chk("basic_checksum_const", 32'(checksum), 32'h02EA);
`endif
        chk($sformatf("v%0d_write_count", idx), 32'(wr_cnt - wr0), 32'(v.len));
        chk($sformatf("v%0d_done_count", idx), 32'(done_cnt - dn0), 32'd1);
        chk($sformatf("v%0d_sb_empty", idx), 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk($sformatf("v%0d_idle_busy", idx), 32'(busy), 32'd0);
`ifdef MEMCOPY_CHECKSUM_EN
        chk($sformatf("v%0d_checksum_held", idx), 32'(checksum), 32'(cs));
`endif
    endtask

    vec_t vt[8];

    initial begin
        vt[0] = '{16'h0010, 16'h0020, 4, -1, 1'b0, 8};   // basic
        vt[1] = '{16'h0030, 16'h0050, 0, -1, 1'b0, 0};   // zero length
        vt[2] = '{16'hFFFF, 16'h0100, 2, -1, 1'b0, 4};   // source wrap through address 0
        vt[3] = '{16'h0200, 16'h0300, 5,  3, 1'b0, 10};  // start while busy
        vt[4] = '{16'h0402, 16'h0400, 6, -1, 1'b0, 12};  // overlap, dst < src
        vt[5] = '{16'h0500, 16'h0502, 6, -1, 1'b0, 12};  // overlap, dst > src
        vt[6] = '{16'h0600, 16'hFFFE, 4, -1, 1'b0, 8};   // destination wrap
        vt[7] = '{16'h0700, 16'h0710, 3, -1, 1'b1, 6};   // start during done

        for (int a = 0; a < 65536; a++) preload(16'(a), pat(16'(a)));
        start = 1'b0;
        src   = 16'h0000;
        dst   = 16'h0000;
        len   = 16'h0000;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_we", 32'(mem_write_en), 32'd0);
        chk("rst_addr", 32'(mem_address), 32'd0);
        chk("rst_in", 32'(mem_in), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Reset mid-copy: only the first two words land.
        ref_mem[16'h0040] = pat(16'h0010);
        ref_mem[16'h0041] = pat(16'h0011);
        exp_q.push_back('{addr: 16'h0040, data: pat(16'h0010)});
        exp_q.push_back('{addr: 16'h0041, data: pat(16'h0011)});
        @(negedge clk);
        start = 1'b1;
        src   = 16'h0010;
        dst   = 16'h0040;
        len   = 16'd8;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_we", 32'(mem_write_en), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_writes", 32'(wr_cnt), 32'd2);
        chk("abort_mem40", 32'(mem[16'h0040]), 32'(pat(16'h0010)));
        chk("abort_mem41", 32'(mem[16'h0041]), 32'(pat(16'h0011)));
        chk("abort_mem42", 32'(mem[16'h0042]), 32'(pat(16'h0042)));
        chk("abort_sb_empty", 32'(exp_q.size()), 32'd0);

        preload(16'h0010, 16'h00A1);
        preload(16'h0011, 16'h00B2);
        preload(16'h0012, 16'h00C3);
        preload(16'h0013, 16'h00D4);
        preload(16'hFFFF, 16'h1234);
        preload(16'h0000, 16'hBEEF);

        for (int v = 0; v < 8; v++) run_vec(vt[v], v);

        chk("basic_mem20", 32'(mem[16'h0020]), 32'h00A1);
        chk("basic_mem23", 32'(mem[16'h0023]), 32'h00D4);
        chk("wrap_mem100", 32'(mem[16'h0100]), 32'h1234);
        chk("wrap_mem101", 32'(mem[16'h0101]), 32'h0000);
        chk("zero_len_dst", 32'(mem[16'h0050]), 32'(pat(16'h0050)));
        chk("glitch_untouched", 32'(mem[16'h0377]), 32'(pat(16'h0377)));
        for (int a = 16'h0400; a < 16'h0508; a++)
            chk($sformatf("mem_%0h", a), 32'(mem[a]), 32'(ref_mem[a]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
